sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/alf_pkg.sv | 27 ++
 rtl/sram_rdcache.sv | 53 +++++
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alf_pkg : shared types and defaults for the SRAM arbiter slice     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alf_pkg;

  localparam int C_ADDR_W       = 21;
  localparam int C_RD_WAIT_DEF  = 2;
  localparam int C_WR_PULSE_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_SETUP  = 3'd1,
    ST_WR_PULSE  = 3'd2,
    ST_WR_HOLD   = 3'd3,
    ST_RD_STROBE = 3'd4,
    ST_DONE      = 3'd5
  } arb_state_e;

  // States in which the arbiter owns MD[7:0].
  function automatic logic is_write_state(input arb_state_e s);
    return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rdcache.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_rdcache : one-entry read cache (tag, byte, valid)             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sram_rdcache
  import alf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_fill,
  input  logic [C_ADDR_W-1:0] i_fill_addr,
  input  logic [7:0]          i_fill_data,
  input  logic                i_inv,
  input  logic [C_ADDR_W-1:0] i_lookup_addr,
  output logic                o_hit,
  output logic [7:0]          o_hit_data
);

  logic                valid_q, valid_d;
  logic [C_ADDR_W-1:0] tag_q, tag_d;
  logic [7:0]          data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (i_inv) begin
      valid_d = 1'b0;
    end else if (i_fill) begin
      valid_d = 1'b1;
      tag_d   = i_fill_addr;
      data_d  = i_fill_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign o_hit      = valid_q && (tag_q == i_lookup_addr);
  assign o_hit_data = data_q;

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_arbiter : loader-write / CPU-read arbiter for a byte SRAM     |
// | Optional read cache: define ALF_SRAM_RDCACHE_EN.        Rev 1.0    |
// +--------------------------------------------------------------------+
module sram_arbiter
  import alf_pkg::*;
#(
  parameter int RD_WAIT  = C_RD_WAIT_DEF,
  parameter int WR_PULSE = C_WR_PULSE_DEF
) (
  input  logic                CLK,
  input  logic                N_RESET,
  input  logic                LD_REQ,
  input  logic [C_ADDR_W-1:0] LD_ADDR,
  input  logic [7:0]          LD_DATA,
  output logic                LD_ACK,
  input  logic                CPU_REQ,
  input  logic [C_ADDR_W-1:0] CPU_ADDR,
  output logic [7:0]          CPU_DO,
  output logic                CPU_ACK,
  output logic [C_ADDR_W-1:0] MA,
  inout  wire  [15:0]         MD,
  output logic [1:0]          MRD_N,
  output logic [1:0]          MWR_N,
  output logic                BUSY
);

  arb_state_e          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [C_ADDR_W-1:0] ma_q, ma_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          cpu_do_q, cpu_do_d;
  logic                ld_ack_q, ld_ack_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                rd_last;
  logic                wr_done;
  logic                hit;
  logic [7:0]          hit_data;

  assign rd_last = (state_q == ST_RD_STROBE) && (cnt_q == 3'(RD_WAIT));
  assign wr_done = (state_q == ST_WR_HOLD);

`ifdef ALF_SRAM_RDCACHE_EN
  sram_rdcache u_rdcache (
    .clk           (CLK),
    .rst_n         (N_RESET),
    .i_fill        (rd_last),
    .i_fill_addr   (ma_q),
    .i_fill_data   (MD[7:0]),
    .i_inv         (wr_done),
    .i_lookup_addr (CPU_ADDR),
    .o_hit         (hit),
    .o_hit_data    (hit_data)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = 8'h00;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ma_d      = ma_q;
    wdata_d   = wdata_q;
    cpu_do_d  = cpu_do_q;
    ld_ack_d  = 1'b0;
    cpu_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (LD_REQ) begin
          ma_d    = LD_ADDR;
          wdata_d = LD_DATA;
          state_d = ST_WR_SETUP;
        // A cache hit acks from IDLE, so the requester still holds CPU_REQ
        // during its ack cycle; cpu_ack_q masks that stale level.
        end else if (CPU_REQ && !cpu_ack_q) begin
          if (hit) begin
            cpu_do_d  = hit_data;
            cpu_ack_d = 1'b1;
          end else begin
            ma_d    = CPU_ADDR;
            cnt_d   = 3'd1;
            state_d = ST_RD_STROBE;
          end
        end
      end
      ST_WR_SETUP: begin
        cnt_d   = 3'd1;
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_q == 3'(WR_PULSE)) state_d = ST_WR_HOLD;
        else                       cnt_d   = cnt_q + 3'd1;
      end
      ST_WR_HOLD: begin
        ld_ack_d = 1'b1;
        state_d  = ST_DONE;
      end
      ST_RD_STROBE: begin
        if (rd_last) begin
          cpu_do_d  = MD[7:0];
          cpu_ack_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      ma_q      <= '0;
      wdata_q   <= 8'h00;
      cpu_do_q  <= 8'hFF;
      ld_ack_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ma_q      <= ma_d;
      wdata_q   <= wdata_d;
      cpu_do_q  <= cpu_do_d;
      ld_ack_q  <= ld_ack_d;
      cpu_ack_q <= cpu_ack_d;
    end
  end

  // Strobes decode straight from state so reset releases them immediately.
  assign MD[7:0]  = is_write_state(state_q) ? wdata_q : 8'hzz;
  assign MD[15:8] = 8'hzz;
  assign MWR_N    = {1'b1, state_q != ST_WR_PULSE};
  assign MRD_N    = {1'b1, is_write_state(state_q)};
  assign MA       = ma_q;
  assign CPU_DO   = cpu_do_q;
  assign LD_ACK   = ld_ack_q;
  assign CPU_ACK  = cpu_ack_q;
  assign BUSY     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sram_arbiter : directed bench for sram_arbiter with SRAM model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sram_arbiter;

  logic        CLK = 1'b0;
  logic        N_RESET;
  logic        LD_REQ;
  logic [20:0] LD_ADDR;
  logic [7:0]  LD_DATA;
  logic        LD_ACK;
  logic        CPU_REQ;
  logic [20:0] CPU_ADDR;
  logic [7:0]  CPU_DO;
  logic        CPU_ACK;
  logic [20:0] MA;
  wire  [15:0] md;
  logic [1:0]  MRD_N;
  logic [1:0]  MWR_N;
  logic        BUSY;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sram_arbiter dut (
    .CLK      (CLK),
    .N_RESET  (N_RESET),
    .LD_REQ   (LD_REQ),
    .LD_ADDR  (LD_ADDR),
    .LD_DATA  (LD_DATA),
    .LD_ACK   (LD_ACK),
    .CPU_REQ  (CPU_REQ),
    .CPU_ADDR (CPU_ADDR),
    .CPU_DO   (CPU_DO),
    .CPU_ACK  (CPU_ACK),
    .MA       (MA),
    .MD       (md),
    .MRD_N    (MRD_N),
    .MWR_N    (MWR_N),
    .BUSY     (BUSY)
  );

  // Byte SRAM model: low 10 address bits, drives data whenever read-enabled.
  logic [7:0] mem [0:1023];
  logic       mem_init = 1'b0;

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h000] <= 8'h5A;
      mem[10'h123] <= 8'h3C;
      mem[10'h200] <= 8'h77;
      mem_init <= 1'b1;
    end else if (!MWR_N[0]) begin
      mem[MA[9:0]] <= md[7:0];
    end
  end

  assign md[7:0] = MRD_N[0] ? 8'hzz : mem[MA[9:0]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    N_RESET = 1'b0; LD_REQ = 1'b0; CPU_REQ = 1'b0;
    LD_ADDR = '0; LD_DATA = '0; CPU_ADDR = '0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (MWR_N !== 2'b11 || MRD_N !== 2'b10) begin
      n_err++; $display("FAIL reset_strobes: got mwr=%b mrd=%b want mwr=11 mrd=10", MWR_N, MRD_N);
    end
    n_vec++;
    if (MA !== 21'h0 || CPU_DO !== 8'hFF) begin
      n_err++; $display("FAIL reset_regs: got ma=%h do=%h want ma=0 do=ff", MA, CPU_DO);
    end
    n_vec++;
    if (LD_ACK !== 1'b0 || CPU_ACK !== 1'b0 || BUSY !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got ld_ack=%b cpu_ack=%b busy=%b want 0 0 0", LD_ACK, CPU_ACK, BUSY);
    end
    N_RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_ld_write();
    logic [1:0] exp_mwr;
    LD_ADDR = 21'h100005; LD_DATA = 8'hA5; LD_REQ = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      exp_mwr = (c == 2 || c == 3) ? 2'b10 : 2'b11;
      n_vec++;
      if (MWR_N !== exp_mwr || MA !== 21'h100005) begin
        n_err++; $display("FAIL ld_write_bus c%0d: got mwr=%b ma=%h want mwr=%b ma=100005", c, MWR_N, MA, exp_mwr);
      end
      if (c <= 4) begin
        n_vec++;
        if (md[7:0] !== 8'hA5 || BUSY !== 1'b1) begin
          n_err++; $display("FAIL ld_write_md c%0d: got md=%h busy=%b want md=a5 busy=1", c, md[7:0], BUSY);
        end
      end
      n_vec++;
      if (LD_ACK !== (c == 5)) begin
        n_err++; $display("FAIL ld_write_ack c%0d: got %b want %b", c, LD_ACK, (c == 5));
      end
      // Inputs change mid-access; the latched values must stand.
      if (c == 1) begin LD_ADDR = 21'h0; LD_DATA = 8'h00; end
    end
    LD_REQ = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (LD_ACK !== 1'b0 || BUSY !== 1'b0 || mem[10'h005] !== 8'hA5) begin
      n_err++; $display("FAIL ld_write_after: got ack=%b busy=%b mem=%h want 0 0 a5", LD_ACK, BUSY, mem[10'h005]);
    end
  endtask

  task automatic test_cpu_read();
    CPU_ADDR = 21'h000123; CPU_REQ = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      n_vec++;
      if (MRD_N !== 2'b10 || MWR_N !== 2'b11 || MA !== 21'h000123) begin
        n_err++; $display("FAIL cpu_read_bus c%0d: got mrd=%b mwr=%b ma=%h want 10 11 000123", c, MRD_N, MWR_N, MA);
      end
      n_vec++;
      if (BUSY !== 1'b1 || CPU_ACK !== (c == 3)) begin
        n_err++; $display("FAIL cpu_read_ctl c%0d: got busy=%b ack=%b want 1 %b", c, BUSY, CPU_ACK, (c == 3));
      end
    end
    n_vec++;
    if (CPU_DO !== 8'h3C) begin
      n_err++; $display("FAIL cpu_read_data: got %h want 3c", CPU_DO);
    end
    CPU_REQ = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_simultaneous();
    int ld_at = -1;
    int cpu_at = -1;
    logic [7:0] seen = 8'h00;
    LD_ADDR = 21'h000010; LD_DATA = 8'h11; CPU_ADDR = 21'h000010;
    LD_REQ = 1'b1; CPU_REQ = 1'b1;
    for (int c = 1; c <= 30 && cpu_at < 0; c++) begin
      @(negedge CLK);
      if (LD_ACK === 1'b1) begin ld_at = c; LD_REQ = 1'b0; end
      if (CPU_ACK === 1'b1) begin cpu_at = c; seen = CPU_DO; CPU_REQ = 1'b0; end
    end
    LD_REQ = 1'b0; CPU_REQ = 1'b0;
    n_vec++;
    if (ld_at != 5 || cpu_at != 9) begin
      n_err++; $display("FAIL simult_order: got ld_ack@%0d cpu_ack@%0d want 5 9", ld_at, cpu_at);
    end
    n_vec++;
    if (seen !== 8'h11) begin
      n_err++; $display("FAIL simult_data: got %h want 11", seen);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int acks [4];
    int nack = 0;
    int cpu_at = -1;
    logic early = 1'b0;
    logic [7:0] seen = 8'h00;
    for (int i = 0; i < 4; i++) acks[i] = -1;
    LD_ADDR = 21'h000300; LD_DATA = 8'hB0; LD_REQ = 1'b1;
    CPU_ADDR = 21'h000123; CPU_REQ = 1'b1;
    for (int c = 1; c <= 60 && cpu_at < 0; c++) begin
      @(negedge CLK);
      if (CPU_ACK === 1'b1) begin
        cpu_at = c; seen = CPU_DO; CPU_REQ = 1'b0;
        if (nack < 4) early = 1'b1;
      end
      if (LD_ACK === 1'b1) begin
        if (nack < 4) acks[nack] = c;
        nack++;
        if (nack < 4) begin
          LD_ADDR = 21'h000300 + 21'(nack);
          LD_DATA = 8'hB0 + 8'(nack);
        end else begin
          LD_REQ = 1'b0;
        end
      end
    end
    LD_REQ = 1'b0; CPU_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (acks[i] != 5 + 6 * i) begin
        n_err++; $display("FAIL b2b_ack%0d: got cycle %0d want %0d", i, acks[i], 5 + 6 * i);
      end
      n_vec++;
      if (mem[10'h300 + 10'(i)] !== 8'hB0 + 8'(i)) begin
        n_err++; $display("FAIL b2b_mem%0d: got %h want %h", i, mem[10'h300 + 10'(i)], 8'hB0 + 8'(i));
      end
    end
    n_vec++;
    if (early || cpu_at != 27 || seen !== 8'h3C) begin
      n_err++; $display("FAIL b2b_cpu: got early=%b ack@%0d do=%h want 0 27 3c", early, cpu_at, seen);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_write();
    int late_acks = 0;
    LD_ADDR = 21'h000040; LD_DATA = 8'hC3; LD_REQ = 1'b1;
    repeat (2) @(negedge CLK);
    n_vec++;
    if (MWR_N !== 2'b10) begin
      n_err++; $display("FAIL rst_mid_pre: got mwr=%b want 10", MWR_N);
    end
    #2 N_RESET = 1'b0;
    #1;
    n_vec++;
    if (MWR_N !== 2'b11 || MRD_N !== 2'b10 || BUSY !== 1'b0 || MA !== 21'h0) begin
      n_err++; $display("FAIL rst_mid_bus: got mwr=%b mrd=%b busy=%b ma=%h want 11 10 0 0", MWR_N, MRD_N, BUSY, MA);
    end
    // Only the SRAM model (mem[0]) may be on MD now.
    n_vec++;
    if (md[7:0] !== 8'h5A) begin
      n_err++; $display("FAIL rst_mid_md: got %h want 5a", md[7:0]);
    end
    LD_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    N_RESET = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (LD_ACK === 1'b1) late_acks++;
      @(negedge CLK);
    end
    n_vec++;
    if (late_acks != 0) begin
      n_err++; $display("FAIL rst_mid_ack: got %0d ld_ack pulses want 0", late_acks);
    end
  endtask

`ifdef ALF_SRAM_RDCACHE_EN
  task automatic test_cache();
    CPU_ADDR = 21'h000200; CPU_REQ = 1'b1;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (CPU_ACK !== 1'b1 || CPU_DO !== 8'h77) begin
      n_err++; $display("FAIL cache_fill: got ack=%b do=%h want 1 77", CPU_ACK, CPU_DO);
    end
    CPU_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    CPU_REQ = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (CPU_ACK !== 1'b1 || CPU_DO !== 8'h77 || BUSY !== 1'b0 || MA !== 21'h000200) begin
      n_err++; $display("FAIL cache_hit: got ack=%b do=%h busy=%b ma=%h want 1 77 0 000200", CPU_ACK, CPU_DO, BUSY, MA);
    end
    CPU_REQ = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (CPU_ACK !== 1'b0 || BUSY !== 1'b0) begin
      n_err++; $display("FAIL cache_hit_once: got ack=%b busy=%b want 0 0", CPU_ACK, BUSY);
    end
    LD_ADDR = 21'h0003FF; LD_DATA = 8'h01; LD_REQ = 1'b1;
    repeat (5) @(negedge CLK);
    LD_REQ = 1'b0;
    @(negedge CLK);
    CPU_REQ = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (CPU_ACK !== 1'b0 || BUSY !== 1'b1 || MA !== 21'h000200) begin
      n_err++; $display("FAIL cache_inval: got ack=%b busy=%b ma=%h want 0 1 000200", CPU_ACK, BUSY, MA);
    end
    repeat (2) @(negedge CLK);
    n_vec++;
    if (CPU_ACK !== 1'b1 || CPU_DO !== 8'h77) begin
      n_err++; $display("FAIL cache_reread: got ack=%b do=%h want 1 77", CPU_ACK, CPU_DO);
    end
    CPU_REQ = 1'b0;
    @(negedge CLK);
  endtask
`endif

  initial begin
    test_reset();
    test_ld_write();
    test_cpu_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_write();
`ifdef ALF_SRAM_RDCACHE_EN
    test_cache();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
